// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-port round-robin arbiter/sequencer in front of the data RAM.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int MEM_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        aReq,
  input  logic        aWrite,
  input  logic        aWord,
  input  logic        aSign,
  input  logic [31:0] aAddress,
  input  logic [31:0] aDataIn,
  output logic        aAck,
  output logic        aErr,
  output logic [31:0] aDataOut,
  input  logic        bReq,
  input  logic        bWrite,
  input  logic        bWord,
  input  logic        bSign,
  input  logic [31:0] bAddress,
  input  logic [31:0] bDataIn,
  output logic        bAck,
  output logic        bErr,
  output logic [31:0] bDataOut,
  output logic [31:0] ramAddress,
  output logic [31:0] ramDataIn,
  output logic        ramWrite,
  output logic        ramWord,
  output logic        ramSign,
  input  logic [31:0] ramDataOut,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] c_WORD_MAX = 32'(MEM_LIMIT - 3);
  localparam logic [31:0] c_HALF_MAX = 32'(MEM_LIMIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_lastB;
  logic        r_grantB;
  logic        r_write;
  logic        r_word;
  logic        r_sign;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        w_any;
  logic        w_pickB;
  logic        w_err;
  logic        w_load_ok;

  // On a tie the port that did not win last time is served.
  always_comb begin
    w_any   = aReq | bReq;
    w_pickB = (aReq && bReq) ? ~r_lastB : bReq;
  end

  always_comb begin
    if (r_word) begin
      w_err = (r_addr[1:0] != 2'b00) || (r_addr > c_WORD_MAX);
    end else begin
      w_err = r_addr[0] || (r_addr > c_HALF_MAX);
    end
    w_load_ok = ~r_write & ~w_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    ramAddress = '0;
    ramDataIn  = '0;
    ramWrite   = 1'b0;
    ramWord    = 1'b0;
    ramSign    = 1'b0;
    aAck       = 1'b0;
    aErr       = 1'b0;
    bAck       = 1'b0;
    bErr       = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy       = 1'b1;
        ramAddress = r_addr;
        ramDataIn  = r_data;
        ramWrite   = r_write & ~w_err;
        ramWord    = r_word;
        ramSign    = r_sign;
        w_next     = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        aAck   = ~r_grantB;
        aErr   = ~r_grantB & w_err;
        bAck   = r_grantB;
        bErr   = r_grantB & w_err;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastB  <= 1'b1;
      r_grantB <= 1'b0;
      r_write  <= 1'b0;
      r_word   <= 1'b0;
      r_sign   <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_grantB <= w_pickB;
      r_lastB  <= w_pickB;
      r_write  <= w_pickB ? bWrite   : aWrite;
      r_word   <= w_pickB ? bWord    : aWord;
      r_sign   <= w_pickB ? bSign    : aSign;
      r_addr   <= w_pickB ? bAddress : aAddress;
      r_data   <= w_pickB ? bDataIn  : aDataIn;
    end
  end

  // Stores and rejected accesses leave zero in the port's data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      aDataOut <= '0;
      bDataOut <= '0;
    end else if (r_state == S_ACCESS) begin
      if (r_grantB) begin
        bDataOut <= w_load_ok ? ramDataOut : '0;
      end else begin
        aDataOut <= w_load_ok ? ramDataOut : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Scoreboard bench for mem_arbiter with a byte RAM and a reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int MEM_LIMIT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        aReq, aWrite, aWord, aSign, aAck, aErr;
  logic [31:0] aAddress, aDataIn, aDataOut;
  logic        bReq, bWrite, bWord, bSign, bAck, bErr;
  logic [31:0] bAddress, bDataIn, bDataOut;
  logic [31:0] ramAddress, ramDataIn, ramDataOut;
  logic        ramWrite, ramWord, ramSign, busy;

  mem_arbiter #(.MEM_LIMIT(MEM_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .aReq(aReq), .aWrite(aWrite), .aWord(aWord), .aSign(aSign),
    .aAddress(aAddress), .aDataIn(aDataIn), .aAck(aAck), .aErr(aErr), .aDataOut(aDataOut),
    .bReq(bReq), .bWrite(bWrite), .bWord(bWord), .bSign(bSign),
    .bAddress(bAddress), .bDataIn(bDataIn), .bAck(bAck), .bErr(bErr), .bDataOut(bDataOut),
    .ramAddress(ramAddress), .ramDataIn(ramDataIn), .ramWrite(ramWrite),
    .ramWord(ramWord), .ramSign(ramSign), .ramDataOut(ramDataOut), .busy(busy)
  );

  always #5 clk = ~clk;

  // Attached RAM: 8-bit cells, little-endian, combinational read, 4-byte write.
  logic [7:0] mem [0:MEM_LIMIT];
  logic       mem_clear;
  logic [7:0] rb0, rb1, rb2, rb3;

  always_comb begin
    rb0 = (ramAddress         <= 32'(MEM_LIMIT)) ? mem[ramAddress[7:0]]        : 8'h00;
    rb1 = (ramAddress + 32'd1 <= 32'(MEM_LIMIT)) ? mem[8'(ramAddress + 32'd1)] : 8'h00;
    rb2 = (ramAddress + 32'd2 <= 32'(MEM_LIMIT)) ? mem[8'(ramAddress + 32'd2)] : 8'h00;
    rb3 = (ramAddress + 32'd3 <= 32'(MEM_LIMIT)) ? mem[8'(ramAddress + 32'd3)] : 8'h00;
    if (ramWord) ramDataOut = {rb3, rb2, rb1, rb0};
    else         ramDataOut = {{16{ramSign & rb1[7]}}, rb1, rb0};
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i <= MEM_LIMIT; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (ramWrite) begin
      for (int k = 0; k < 4; k++)
        if (ramAddress + 32'(k) <= 32'(MEM_LIMIT)) mem[8'(ramAddress + 32'(k))] <= ramDataIn[8*k +: 8];
    end
  end

  // Reference model and scoreboard
  typedef struct { logic write; logic word; logic sign; logic [31:0] addr; logic [31:0] data; } tx_t;
  typedef struct { logic err; logic [31:0] data; logic wr; int ack_cyc; logic portB; } exp_t;

  logic [7:0] mm [0:MEM_LIMIT];
  tx_t  qA[$], qB[$];
  exp_t expA[$], expB[$];
  logic ordq[$];
  tx_t  curA, curB;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic m_lastB;
  int   m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tx_t mk(input logic w, input logic wd, input logic s, input logic [31:0] a, input logic [31:0] d);
    tx_t t;
    t.write = w; t.word = wd; t.sign = s; t.addr = a; t.data = d;
    return t;
  endfunction

  // Executes one access against the model memory and returns the expected response.
  function automatic exp_t model_access(input tx_t t, input logic pb);
    exp_t        e;
    logic [31:0] lim;
    logic [31:0] v;
    logic        ok;
    lim = t.word ? 32'(MEM_LIMIT - 3) : 32'(MEM_LIMIT - 1);
    ok  = ((t.addr % (t.word ? 32'd4 : 32'd2)) == 0) && (t.addr <= lim);
    e.err = !ok; e.wr = t.write && ok; e.data = '0; e.portB = pb; e.ack_cyc = 0;
    if (ok && t.write) begin
      for (int k = 0; k < 4; k++)
        if (t.addr + 32'(k) <= 32'(MEM_LIMIT)) mm[8'(t.addr + 32'(k))] = t.data[8*k +: 8];
    end else if (ok) begin
      v = '0;
      for (int k = 0; k < (t.word ? 4 : 2); k++) v = v + (32'(mm[8'(t.addr + 32'(k))]) << (8 * k));
      if (t.word)                      e.data = v;
      else if (t.sign && v >= 32'h8000) e.data = v - 32'h10000;
      else                             e.data = v;
    end
    return e;
  endfunction

  // One negedge of stimulus: handshake, new requests, and model arbitration.
  task automatic drive_cycle(input int pct);
    exp_t e;
    logic pb;
    if (aReq && aAck) aReq = 1'b0;
    if (bReq && bAck) bReq = 1'b0;
    if (!aReq && qA.size() > 0 && $urandom_range(99) < pct) begin
      curA = qA.pop_front();
      aReq = 1'b1; aWrite = curA.write; aWord = curA.word; aSign = curA.sign;
      aAddress = curA.addr; aDataIn = curA.data;
    end
    if (!bReq && qB.size() > 0 && $urandom_range(99) < pct) begin
      curB = qB.pop_front();
      bReq = 1'b1; bWrite = curB.write; bWord = curB.word; bSign = curB.sign;
      bAddress = curB.addr; bDataIn = curB.data;
    end
    if (m_cnt > 0) begin
      m_cnt--;
    end else if (aReq || bReq) begin
      pb = (aReq && bReq) ? !m_lastB : bReq;
      e = model_access(pb ? curB : curA, pb);
      e.ack_cyc = cyc + 2;
      if (pb) expB.push_back(e); else expA.push_back(e);
      ordq.push_back(pb);
      m_lastB = pb;
      m_cnt = 2;
    end
  endtask

  task automatic run(input int pct, input int budget);
    int n = 0;
    while ((qA.size() > 0 || qB.size() > 0 || aReq || bReq || expA.size() > 0 || expB.size() > 0) && n < budget) begin
      @(negedge clk);
      drive_cycle(pct);
      n++;
    end
    if (n >= budget) begin
      errors++; checks++;
      $display("FAIL run_timeout: got %0d pending expected 0", qA.size() + qB.size() + expA.size() + expB.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; aReq = 1'b0; bReq = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_lastB = 1'b1; m_cnt = 0;
  endtask

  // Monitor: pops expectations whenever a port acknowledges.
  logic prev_wr = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      if (aAck && bAck) chk("dual_ack", {aAck, bAck}, 2'b10);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? aAck : bAck) begin
          if (((p == 0) ? expA.size() : expB.size()) == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_ack: got ack on port %0d expected none", p);
          end else begin
            me = (p == 0) ? expA.pop_front() : expB.pop_front();
            chk(p == 0 ? "A_ack_cycle" : "B_ack_cycle", 64'(cyc), 64'(me.ack_cyc));
            chk(p == 0 ? "A_err" : "B_err", (p == 0) ? aErr : bErr, me.err);
            chk(p == 0 ? "A_dataOut" : "B_dataOut", (p == 0) ? aDataOut : bDataOut, me.data);
            chk(p == 0 ? "A_ramWrite" : "B_ramWrite", prev_wr, me.wr);
            if (ordq.size() > 0) chk("grant_order", 64'(p), 64'(ordq.pop_front()));
          end
        end
      end
      if (ramWrite) chk("ramWrite_outside_access", busy, 1'b1);
    end
    prev_wr <= ramWrite;
  end

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(9))
      0:       return $urandom;
      1, 2:    return 32'(MEM_LIMIT) - 32'($urandom_range(7));
      3:       return 32'($urandom_range(MEM_LIMIT));
      default: return 32'($urandom_range(MEM_LIMIT)) & ~32'd3;
    endcase
  endfunction

  initial begin
    reset = 1'b1; mem_clear = 1'b1;
    aReq = 0; aWrite = 0; aWord = 0; aSign = 0; aAddress = 0; aDataIn = 0;
    bReq = 0; bWrite = 0; bWord = 0; bSign = 0; bAddress = 0; bDataIn = 0;
    for (int i = 0; i <= MEM_LIMIT; i++) mm[i] = 8'(i * 7 + 3);
    m_lastB = 1'b1; m_cnt = 0;
    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    chk("rst_acks_errs", {aAck, bAck, aErr, bErr}, 4'b0);
    chk("rst_aDataOut", aDataOut, 32'h0);
    chk("rst_bDataOut", bDataOut, 32'h0);
    chk("rst_ram_ctl", {ramWrite, ramWord, ramSign}, 3'b0);
    chk("rst_ramAddress", ramAddress, 32'h0);
    chk("rst_ramDataIn", ramDataIn, 32'h0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Store then reload, word and both half-word extensions.
    qB.push_back(mk(1, 1, 0, 200, 32'hF00FF176)); run(100, 50);
    qA.push_back(mk(0, 1, 0, 200, 0)); run(100, 50);
    chk("A_load_word_200", aDataOut, 32'hF00FF176);
    qA.push_back(mk(0, 0, 1, 200, 0)); run(100, 50);
    chk("A_load_half_signed", aDataOut, 32'hFFFFF176);
    qA.push_back(mk(0, 0, 0, 200, 0)); run(100, 50);
    chk("A_load_half_unsigned", aDataOut, 32'h0000F176);

    // Simultaneous requests right after reset, held for four transactions.
    do_reset();
    qA.push_back(mk(0, 1, 0, 200, 0)); qA.push_back(mk(0, 1, 0, 204, 0));
    qB.push_back(mk(0, 0, 1, 200, 0)); qB.push_back(mk(0, 1, 0, 0, 0));
    run(100, 60);

    // Misaligned and out-of-range stores, then verify the region is untouched.
    qB.push_back(mk(1, 1, 0, 201, 32'h11111111)); run(100, 50);
    chk("B_err_dataOut_201", bDataOut, 32'h0);
    qB.push_back(mk(1, 1, 0, 254, 32'h22222222)); run(100, 50);
    chk("B_err_dataOut_254", bDataOut, 32'h0);
    for (int a = 200; a <= 252; a += 4) qA.push_back(mk(0, 1, 0, 32'(a), 0));
    run(100, 200);

    // Upper-boundary half and word accesses.
    qB.push_back(mk(1, 0, 0, 254, 32'h00001234)); run(100, 50);
    chk("B_half_store_254_err", bErr, 1'b0);
    qA.push_back(mk(0, 1, 0, 252, 0)); qA.push_back(mk(0, 1, 0, 253, 0));
    qA.push_back(mk(0, 0, 0, 254, 0));
    run(100, 60);
    chk("A_half_load_254", aDataOut, 32'h00001234);

    // Reset lands on the ACCESS cycle of a store.
    @(negedge clk);
    aReq = 1; aWrite = 1; aWord = 1; aSign = 0; aAddress = 8; aDataIn = 32'hDEADBEEF;
    @(negedge clk);
    chk("midrst_ramWrite", ramWrite, 1'b1);
    reset = 1'b1; aReq = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_aAck", aAck, 1'b0);
    @(negedge clk);
    chk("midrst_aAck_late", aAck, 1'b0);
    reset = 1'b0;
    me = model_access(mk(1, 1, 0, 8, 32'hDEADBEEF), 1'b0);
    m_lastB = 1'b1; m_cnt = 0;
    qA.push_back(mk(0, 1, 0, 8, 0)); run(100, 50);
    chk("A_load_after_midrst", aDataOut, 32'hDEADBEEF);

    // Randomized traffic on both ports.
    for (int i = 0; i < 120; i++) begin
      qA.push_back(mk(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), rnd_addr(), $urandom));
      qB.push_back(mk(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), rnd_addr(), $urandom));
    end
    run(40, 5000);
    chk("leftover_expectations", 64'(expA.size() + expB.size() + ordq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed data RAM (8-bit cells, word/half-word, signed/unsigned half loads, combinational read, posedge write).
- Port A serves instruction fetch; port B serves the load/store stage.
- Latches one request at a time, checks alignment and range, and drives the RAM for exactly one cycle.
- Returns read data, or a write completion, with a one-cycle ack pulse; round-robin between ports on conflict.

Parameters:
MEM_LIMIT, 255, highest valid byte address of the attached RAM.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
aReq  in  1  port A request; held high until aAck
aWrite  in  1  port A: 1 = store, 0 = load
aWord  in  1  port A: 1 = 4-byte access, 0 = 2-byte access
aSign  in  1  port A: half-word load sign-extend (1) or zero-extend (0)
aAddress  in  32  port A byte address
aDataIn  in  32  port A store data
aAck  out  1  port A completion pulse
aErr  out  1  port A error flag, valid with aAck
aDataOut  out  32  port A load data, held until next port A ack
bReq, bWrite, bWord, bSign, bAddress, bDataIn, bAck, bErr, bDataOut: same as port A, for port B
ramAddress  out  32  to RAM address
ramDataIn  out  32  to RAM dataIn
ramWrite  out  1  to RAM write
ramWord  out  1  to RAM word
ramSign  out  1  to RAM sign
ramDataOut  in  32  from RAM dataOut (combinational read)
busy  out  1  high in ACCESS and DONE states

Behaviour:
- Reset values: state IDLE; all outputs 0; lastGrant = B, so A wins the first tie.
- State IDLE
  - ram* outputs = 0.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != lastGrant.
  - On grant: latch write/word/sign/address/dataIn, set lastGrant, go to ACCESS.
  - If no req, stay in IDLE.
- Error check, evaluated on the latched request:
  - Word access: err if address[1:0] != 0 or address > MEM_LIMIT-3.
  - Half access: err if address[0] != 0 or address > MEM_LIMIT-1.
- State ACCESS (1 cycle)
  - Drive ramAddress/ramDataIn/ramWord/ramSign from the latch.
  - ramWrite = latched write AND NOT err; the RAM commits at the edge ending ACCESS.
  - At that edge, capture ramDataOut into the granted port's dataOut register on a non-err load; otherwise load 0.
  - Next state DONE.
- State DONE (1 cycle)
  - Granted port's ack = 1 and err = latched err.
  - ram* outputs = 0.
  - Next state IDLE.
  - The other port's ack stays 0.
- Handshake
  - Requester keeps req and its fields stable from assertion until it samples ack = 1, then drops req at that same edge.
  - A req still high in IDLE after its ack is treated as a new request.
- Latency and throughput
  - Req sampled at edge N; ACCESS runs cycle N+1; ack in cycle N+2.
  - One access per 3 cycles.
- Fairness
  - Continuous requests from both ports alternate A, B, A, B.
  - A lone requester is never blocked.
- Data rule
  - dataOut passes RAM data unmodified; width and extension are handled by the RAM via ramWord/ramSign.
  - Store data in half mode writes all 4 bytes, per RAM behaviour; this is the caller's concern.
- Reset mid-operation
  - A write whose ACCESS cycle coincides with the reset edge is committed.
  - No ack is issued; the state returns to IDLE.
  - Requesters must re-issue any transaction in flight at reset.
- Req deasserted before ack (protocol violation): the transaction still completes and acks; it is not cancelled.

Test Plan:
- Reset, then B store word 0xF00FF176 @200 -> bAck in cycle 3 after req, bErr = 0. Then A load word @200 -> aDataOut = 0xF00FF176.
- After that, A half load @200 with sign=1 -> 0xFFFFF176; with sign=0 -> 0x0000F176.
- A and B both request in the same IDLE cycle, first after reset -> A served first, B acked 3 cycles later. Hold both reqs for 4 transactions -> order A, B, A, B.
- B store word @201 (misaligned) and @254 (out of range) -> bErr = 1, bDataOut = 0, ramWrite never high, memory @200..255 unchanged.
- Half store 0x00001234 @254 -> err = 0 (254 <= MEM_LIMIT-1); a word access @252 is accepted, @253 errs.
- Assert reset during the ACCESS cycle of an A store 0xDEADBEEF @8 -> no aAck, busy = 0 next cycle. A subsequent load @8 returns 0xDEADBEEF.
